// File: rtl/sub_serial_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// The default width matches the serial adder so the two can share operand buses.
package sub_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/serial_full_sub.sv
// One-bit full subtractor: d = x - y - bin, bout = borrow out.
module serial_full_sub (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor, LSB first, one bit per clock over WIDTH cycles.
// Optional SUB_SERIAL_SAT_EN: clamp the result to zero on underflow.
//
//   state | meaning
//   IDLE  | waiting for en; out/borrow hold the previous result
//   SUB   | shifting one difference bit per cycle
//   DONE  | result valid; waits for en to drop
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  sub_state_t       state;
  sub_state_t       state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [CNT_W-1:0] count;
  logic             d;
  logic             bn;
  logic             last;

  serial_full_sub u_full_sub (
    .x    (a_reg[0]),
    .y    (b_reg[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bn)
  );

  assign last = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = SUB;
      SUB:     if (last) state_next = DONE;
      DONE:    if (!en) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            a_reg  <= a;
            b_reg  <= b;
            borrow <= 1'b0;
            count  <= '0;
            out    <= '0;
          end
        end
        SUB: begin
          out    <= {d, out[WIDTH-1:1]};
          borrow <= bn;
          a_reg  <= a_reg >> 1;
          b_reg  <= b_reg >> 1;
          count  <= last ? '0 : count + CNT_W'(1);
`ifdef SUB_SERIAL_SAT_EN
          if (last && bn) out <= '0;
`endif
        end
        // DONE holds the result; the illegal encoding only repairs state.
        default: ;
      endcase
    end
  end

  assign busy = (state == SUB);
  assign done = (state == DONE);

endmodule
